// File: rtl/seven_segment_scanner_pkg.sv
// Shared constants and helpers for the seven-segment scanner: select
// polarity, scan state encoding and prescaler width sizing.
package seven_segment_scanner_pkg;

  localparam logic SELECT_ACTIVE_LOW  = 1'b1;
  localparam logic SELECT_ACTIVE_HIGH = 1'b0;

  typedef enum logic {
    STATE_BLANK = 1'b0,
    STATE_DRIVE = 1'b1
  } scan_state_e;

  function automatic int unsigned counter_width(input int unsigned divider);
    if (divider > 32'd1) begin
      return $clog2(divider);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/seven_segment_scanner_scan_prescaler.sv
// Modulo-REFRESH_DIVIDER slot counter; strobes the last cycle of the slot
// and the last cycle of the anti-ghosting blank window.
module scan_prescaler
  import seven_segment_scanner_pkg::*;
#(
  parameter int REFRESH_DIVIDER = 50000,
  parameter int GHOST_CYCLES    = 500
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic slot_end_o,
  output logic ghost_end_o
);

  localparam int CW = counter_width(REFRESH_DIVIDER);
  localparam logic [CW-1:0] LAST_COUNT = CW'(REFRESH_DIVIDER - 1);
  localparam logic [CW-1:0] GHOST_LAST = CW'((GHOST_CYCLES > 0) ? (GHOST_CYCLES - 1) : 0);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: wrap to zero after the terminal count.
  always_comb begin
    count_d = count_q;
    if (count_q == LAST_COUNT) begin
      count_d = {CW{1'b0}};
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign slot_end_o  = (count_q == LAST_COUNT);
  assign ghost_end_o = (count_q == GHOST_LAST);

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed hex display driver: double-buffered value (swapped only at
// frame boundaries), blank/drive slot FSM, leading-zero blanking, polarity.
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int REFRESH_DIVIDER = 50000,
  parameter int GHOST_CYCLES    = 500
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] display_value,
  input  logic                    load,
  input  logic                    blank_leading_zeros,
  input  logic                    common_anod,
  output logic [3:0]              four_bit_number,
  output logic [NUM_DIGITS-1:0]   digit_select,
  output logic                    frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_DIGIT = IW'(NUM_DIGITS - 1);

  logic                    slot_end_s;
  logic                    ghost_end_s;
  logic                    frame_boundary_s;
  logic                    suppress_s;
  logic [3:0]              current_nibble_s;
  logic [NUM_DIGITS-1:0]   onehot_s;
  logic [NUM_DIGITS-1:0]   raw_select_s;

  scan_state_e             state_q, state_d;
  logic [IW-1:0]           digit_index_q, digit_index_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [3:0]              nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0]   select_q, select_d;
  logic                    frame_done_q, frame_done_d;

  scan_prescaler #(
    .REFRESH_DIVIDER(REFRESH_DIVIDER),
    .GHOST_CYCLES   (GHOST_CYCLES)
  ) u_prescaler (
    .clk_i      (clock),
    .rst_i      (reset),
    .slot_end_o (slot_end_s),
    .ghost_end_o(ghost_end_s)
  );

  assign frame_boundary_s = slot_end_s && (digit_index_q == LAST_DIGIT);
  assign current_nibble_s = active_q[4*digit_index_q +: 4];
  assign onehot_s         = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_index_q;

  // A digit above 0 is suppressed when it and every more significant nibble is zero.
  always_comb begin
    suppress_s = 1'b0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if ((IW'(i) == digit_index_q) && blank_leading_zeros &&
          ((active_q >> (4*i)) == {(4*NUM_DIGITS){1'b0}})) begin
        suppress_s = 1'b1;
      end else begin
        suppress_s = suppress_s;
      end
    end
  end

  // Next-state logic for scan position, buffers, FSM and output registers.
  always_comb begin
    digit_index_d = digit_index_q;
    state_d       = state_q;
    raw_select_s  = {NUM_DIGITS{1'b0}};

    if (slot_end_s) begin
      if (digit_index_q == LAST_DIGIT) begin
        digit_index_d = {IW{1'b0}};
      end else begin
        digit_index_d = digit_index_q + IW'(1);
      end
    end else begin
      digit_index_d = digit_index_q;
    end

    if (load) begin
      pending_d = display_value;
    end else begin
      pending_d = pending_q;
    end

    // Old pending moves to active even when a load lands on the boundary.
    if (frame_boundary_s) begin
      active_d = pending_q;
    end else begin
      active_d = active_q;
    end

    frame_done_d = frame_boundary_s;

    case (state_q)
      STATE_BLANK: begin
        if (slot_end_s) begin
          state_d = STATE_BLANK;
        end else if (ghost_end_s) begin
          state_d = STATE_DRIVE;
        end else begin
          state_d = STATE_BLANK;
        end
      end
      STATE_DRIVE: begin
        if (slot_end_s) begin
          state_d = STATE_BLANK;
        end else begin
          state_d = STATE_DRIVE;
        end
      end
      default: state_d = STATE_BLANK;
    endcase

    if (state_q == STATE_BLANK) begin
      nibble_d = current_nibble_s;
    end else begin
      nibble_d = nibble_q;
    end

    if ((state_q == STATE_DRIVE) && !suppress_s) begin
      raw_select_s = onehot_s;
    end else begin
      raw_select_s = {NUM_DIGITS{1'b0}};
    end

    if (common_anod == SELECT_ACTIVE_LOW) begin
      select_d = ~raw_select_s;
    end else begin
      select_d = raw_select_s;
    end
  end

  // State and registered outputs; select resets to the inactive level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= STATE_BLANK;
      digit_index_q <= {IW{1'b0}};
      pending_q     <= {(4*NUM_DIGITS){1'b0}};
      active_q      <= {(4*NUM_DIGITS){1'b0}};
      nibble_q      <= 4'd0;
      select_q      <= {NUM_DIGITS{common_anod}};
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      digit_index_q <= digit_index_d;
      pending_q     <= pending_d;
      active_q      <= active_d;
      nibble_q      <= nibble_d;
      select_q      <= select_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign four_bit_number = nibble_q;
  assign digit_select    = select_q;
  assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner: table-driven frame checks,
// hand-written buffering/reset sequences and a randomized cycle model.
module tb_seven_segment_scanner;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int G  = 1;
  localparam int FRAME = N * RD;

  logic          clock;
  logic          reset;
  logic [15:0]   display_value;
  logic          load;
  logic          blank_leading_zeros;
  logic          common_anod;
  logic [3:0]    four_bit_number;
  logic [3:0]    digit_select;
  logic          frame_done;

  seven_segment_scanner #(
    .NUM_DIGITS     (N),
    .REFRESH_DIVIDER(RD),
    .GHOST_CYCLES   (G)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .display_value      (display_value),
    .load               (load),
    .blank_leading_zeros(blank_leading_zeros),
    .common_anod        (common_anod),
    .four_bit_number    (four_bit_number),
    .digit_select       (digit_select),
    .frame_done         (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: k counts clock edges since reset release.
  int          k;
  logic [15:0] m_active, m_pending;
  logic [3:0]  m_nib, m_sel;
  logic        m_fd;

  typedef struct {
    logic [15:0] value;
    logic        blz;
    logic        ca;
    logic [3:0]  exp_mask;
    logic [15:0] exp_nibs;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, k);
    end
  endtask

  function automatic logic [3:0] exp_select(input int cyc, input logic [15:0] act,
                                            input logic blz, input logic ca);
    int p;
    int idx;
    logic [3:0] v;
    p   = cyc % RD;
    idx = (cyc / RD) % N;
    v   = 4'b0000;
    if (p >= G && (idx == 0 || !blz || (act >> (4*idx)) != 16'd0)) v[idx] = 1'b1;
    return ca ? ~v : v;
  endfunction

  task automatic model_reset();
    k         = 0;
    m_active  = 16'd0;
    m_pending = 16'd0;
    m_nib     = 4'd0;
    m_fd      = 1'b0;
    m_sel     = {N{common_anod}};
  endtask

  task automatic tick();
    int p;
    int idx;
    bit boundary;
    logic [3:0] n_sel, n_nib;
    logic [15:0] n_act, n_pend;
    p        = k % RD;
    idx      = (k / RD) % N;
    boundary = ((k % FRAME) == FRAME - 1);
    n_sel    = exp_select(k, m_active, blank_leading_zeros, common_anod);
    n_nib    = (p < G) ? m_active[4*idx +: 4] : m_nib;
    n_act    = boundary ? m_pending : m_active;
    n_pend   = load ? display_value : m_pending;
    @(posedge clock);
    #1;
    k++;
    m_sel     = n_sel;
    m_nib     = n_nib;
    m_fd      = boundary;
    m_active  = n_act;
    m_pending = n_pend;
    check("model_select", {28'd0, digit_select}, {28'd0, m_sel});
    check("model_nibble", {28'd0, four_bit_number}, {28'd0, m_nib});
    check("model_frame_done", {31'd0, frame_done}, {31'd0, m_fd});
  endtask

  task automatic wait_fd(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (frame_done !== 1'b1 && n < 40);
    check(name, {31'd0, frame_done}, 32'd1);
  endtask

  task automatic wait_select(input logic [3:0] pattern, input string name);
    int n = 0;
    while (digit_select !== pattern && n < 40) begin
      tick();
      n++;
    end
    check(name, {28'd0, digit_select}, {28'd0, pattern});
  endtask

  initial begin
    logic [3:0] seen2, seen3;
    int n;

    vecs[0] = '{16'h1A2F, 1'b0, 1'b1, 4'b1111, 16'h1A2F};
    vecs[1] = '{16'h0040, 1'b1, 1'b1, 4'b0011, 16'h0040};
    vecs[2] = '{16'h0000, 1'b1, 1'b1, 4'b0001, 16'h0000};
    vecs[3] = '{16'h1A2F, 1'b0, 1'b0, 4'b1111, 16'h1A2F};
    vecs[4] = '{16'h0900, 1'b1, 1'b0, 4'b0111, 16'h0900};
    vecs[5] = '{16'h0040, 1'b0, 1'b1, 4'b1111, 16'h0040};

    reset = 1'b1;
    load = 1'b0;
    display_value = 16'd0;
    blank_leading_zeros = 1'b0;
    common_anod = 1'b1;
    k = 0;
    #2;
    check("reset_select", {28'd0, digit_select}, 32'hF);
    check("reset_nibble", {28'd0, four_bit_number}, 32'd0);
    check("reset_frame_done", {31'd0, frame_done}, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    model_reset();

    // Table-driven frames: load, let it become active, observe one full scan.
    for (int v = 0; v < 6; v++) begin
      int sel_cycles[4];
      logic [3:0] seen_nib[4];
      logic [3:0] mask;
      int fd_count;
      blank_leading_zeros = vecs[v].blz;
      common_anod = vecs[v].ca;
      display_value = vecs[v].value;
      load = 1'b1;
      tick();
      load = 1'b0;
      wait_fd($sformatf("vec%0d_frame_done", v));
      fd_count = 0;
      for (int d = 0; d < 4; d++) begin
        sel_cycles[d] = 0;
        seen_nib[d] = 4'd0;
      end
      for (int c = 0; c < FRAME; c++) begin
        tick();
        if (frame_done === 1'b1) fd_count++;
        for (int d = 0; d < 4; d++) begin
          if (digit_select[d] === ~vecs[v].ca) begin
            sel_cycles[d]++;
            seen_nib[d] = four_bit_number;
          end
        end
      end
      for (int d = 0; d < 4; d++) mask[d] = (sel_cycles[d] != 0);
      check($sformatf("vec%0d_mask", v), {28'd0, mask}, {28'd0, vecs[v].exp_mask});
      check($sformatf("vec%0d_fd_per_frame", v), fd_count, 32'd1);
      for (int d = 0; d < 4; d++) begin
        if (vecs[v].exp_mask[d]) begin
          check($sformatf("vec%0d_digit%0d_cycles", v, d), sel_cycles[d], 32'd3);
          check($sformatf("vec%0d_digit%0d_nibble", v, d), {28'd0, seen_nib[d]},
                {28'd0, vecs[v].exp_nibs[4*d +: 4]});
        end
      end
    end

    // Mid-frame load at digit 1: the rest of the frame keeps the old value.
    common_anod = 1'b1;
    blank_leading_zeros = 1'b0;
    display_value = 16'h1A2F;
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_fd("midload_align");
    wait_select(4'b1101, "midload_digit1");
    display_value = 16'h1234;
    load = 1'b1;
    tick();
    load = 1'b0;
    seen2 = 4'd0;
    seen3 = 4'd0;
    n = 0;
    do begin
      tick();
      n++;
      if (digit_select === 4'b1011) seen2 = four_bit_number;
      if (digit_select === 4'b0111) seen3 = four_bit_number;
    end while (frame_done !== 1'b1 && n < 40);
    check("midload_old_digit2", {28'd0, seen2}, 32'hA);
    check("midload_old_digit3", {28'd0, seen3}, 32'h1);
    wait_select(4'b1110, "midload_new_digit0");
    check("midload_new_nibble0", {28'd0, four_bit_number}, 32'h4);

    // Load on the boundary cycle: previous pending shows first, new one a frame later.
    display_value = 16'hABCD;
    load = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
    while ((k % FRAME) != FRAME - 1 && n < 40) begin
      tick();
      n++;
    end
    display_value = 16'h5678;
    load = 1'b1;
    tick();
    load = 1'b0;
    check("boundary_frame_done", {31'd0, frame_done}, 32'd1);
    wait_select(4'b1110, "boundary_digit0_a");
    check("boundary_old_pending", {28'd0, four_bit_number}, 32'hD);
    wait_fd("boundary_next_frame");
    wait_select(4'b1110, "boundary_digit0_b");
    check("boundary_new_value", {28'd0, four_bit_number}, 32'h8);

    // Asynchronous reset while a digit is being driven.
    tests++;
    if (digit_select === 4'b1111) begin
      fails++;
      $display("FAIL midreset_precondition: got %0h expected a driven digit", digit_select);
    end
    reset = 1'b1;
    #1;
    check("midreset_select", {28'd0, digit_select}, 32'hF);
    check("midreset_nibble", {28'd0, four_bit_number}, 32'd0);
    check("midreset_frame_done", {31'd0, frame_done}, 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    model_reset();
    tick();
    check("restart_blank", {28'd0, digit_select}, 32'hF);
    tick();
    check("restart_digit0", {28'd0, digit_select}, 32'hE);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      load = ($urandom_range(0, 7) == 0);
      display_value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) display_value[15:8] = 8'd0;
      if ((c % 37) == 0) begin
        blank_leading_zeros = 1'($urandom_range(0, 1));
        common_anod = 1'($urandom_range(0, 1));
      end
      tick();
    end
    load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Time-multiplexes an NUM_DIGITS-digit hexadecimal value onto one shared seven-segment bus.
- Sits directly upstream of the seven-segment translator: drives its four_bit_number input and the per-digit select lines on the board.
- Provides tear-free value updates, anti-ghosting blank time and leading-zero blanking.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; legal range 2..8.
- REFRESH_DIVIDER, 50000: clock cycles per digit slot; must be at least 2.
- GHOST_CYCLES, 500: cycles at the start of each slot with all digits off; must be less than REFRESH_DIVIDER.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- display_value  input  4*NUM_DIGITS  value to display; nibble i drives digit i, and digit 0 is least significant.
- load  input  1  single-cycle strobe that captures display_value into the pending register.
- blank_leading_zeros  input  1  when 1, suppress leading zero digits; sampled each cycle.
- common_anod  input  1  1 means digit selects are active-low; 0 means active-high.
- four_bit_number  output  4  nibble for the digit currently being driven, fed to the translator.
- digit_select  output  NUM_DIGITS  one-hot digit enable, with polarity set by common_anod.
- frame_done  output  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - prescaler, digit_index, pending, active, four_bit_number and frame_done to 0;
  - state to BLANK;
  - digit_select to all-inactive (all 1 if common_anod=1, all 0 otherwise).
- Prescaler counts 0..REFRESH_DIVIDER-1 and wraps to 0. Terminal count is slot_end.
- digit_index advances on slot_end and wraps from NUM_DIGITS-1 to 0.
- Frame boundary is slot_end when digit_index=NUM_DIGITS-1. On that cycle:
  - active <= pending;
  - frame_done=1 on the following cycle, for exactly 1 cycle.
- Update rule for pending and active:
  - load captures display_value into pending on the same edge.
  - load on the frame-boundary cycle: pending takes the new value, and active takes the old pending. The new value appears in the next frame.
  - active never changes mid-frame, so there is no tearing.
- State machine, 2 states:
  - BLANK: entered on slot_end and at reset. All digits inactive. Moves to DRIVE when prescaler reaches GHOST_CYCLES-1.
  - DRIVE: the selected digit is active. Moves to BLANK on slot_end.
- Outputs are registered, with 1 cycle latency from the state/index change.
  - four_bit_number = active nibble[digit_index]; it is updated in BLANK so it is stable before the select asserts.
- Leading-zero blanking:
  - Digit i (i>0) is suppressed when blank_leading_zeros=1 and active nibbles i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps its select inactive during DRIVE. Slot timing is unchanged.
- Polarity: common_anod is applied combinationally at the output register input. A change takes effect on the next clock.
- Reset mid-slot aborts immediately to the reset values. The scan restarts at digit 0 with a full BLANK period.

Decomposition:
- Shared package holds:
  - selection-polarity constants (SELECT_ACTIVE_LOW / SELECT_ACTIVE_HIGH);
  - scan state encoding (STATE_BLANK=0, STATE_DRIVE=1);
  - a function computing the counter width from REFRESH_DIVIDER.
- One natural sub-module: scan_prescaler. It holds the modulo-REFRESH_DIVIDER counter and provides the slot_end and ghost_end strobes.

Test Plan:
Benches use NUM_DIGITS=4, REFRESH_DIVIDER=4, GHOST_CYCLES=1.
- Reset with common_anod=1 -> digit_select=4'b1111, four_bit_number=0, frame_done=0. Hold reset mid-DRIVE -> outputs return to these values without waiting for a clock.
- Load 16'h1A2F and wait one frame -> each digit is active for 3 cycles after a 1-cycle blank, in order 0..3. four_bit_number is F,2,A,1 while digits 0..3 are selected. frame_done pulses once per 16 cycles.
- Load 16'h1234 at mid-frame, digit 1 -> the remainder of the frame still shows the old value; 4 (digit 0) first appears after frame_done.
- Load on the exact frame-boundary cycle -> the new value is deferred by one full frame.
- blank_leading_zeros=1 with 16'h0040 -> digits 3 and 2 are never selected; digits 1 and 0 are selected showing 4 and 0. With 16'h0000, only digit 0 is selected, showing 0.
- Toggle common_anod=0 -> the active digit reads 1 among 0s; the blank period shows 4'b0000.
